// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, out-of-range
// read word, default depth and a small port-index helper.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    StFree  = 2'd0,
    StLock0 = 2'd1,
    StLock1 = 2'd2
  } arb_state_e;

  localparam logic [31:0] OorData   = 32'hDEAD_BEEF;
  localparam int unsigned DmemDepth = 128;

  // One-hot grant vector for a single port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: masked requests, ties go to the port that did
// not win most recently.
module dmem_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  logic [1:0] elig;

  assign elig = req & ~mask;

  // Single eligible port wins outright; a tie goes to the port other than last_gnt.
  always_comb begin
    gnt = elig;
    if (elig == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU (port 0) and a DMA/debug
// loader (port 1). Per-cycle round-robin with a bounded lock burst; the read
// word is registered back to the winning port one cycle after the grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DEPTH     = DmemDepth,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_writeData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  output logic              mem_MemtoReg,
  output logic [31:0]       mem_ALUResult,
  input  logic [31:0]       mem_readData
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t MaxCnt = cnt_t'(MAX_BURST);

  arb_state_e state_q, state_d;
  cnt_t       burst_q, burst_d;
  logic       last_gnt_q, last_gnt_d;

  logic [1:0]             req, we, lock;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][31:0]       wdata;
  logic [1:0]             gnt, rr_gnt, arb_mask;

  logic              in_lock, owner, owner_wants, owner_cont, burst_exit;
  logic              any_gnt, sel, sel_in_range;
  logic [ADDR_W-1:0] sel_addr;

  logic [1:0]       rvalid_q, err_q;
  logic [1:0][31:0] rdata_q;

  assign req   = {p1_req, p0_req};
  assign we    = {p1_we, p0_we};
  assign lock  = {p1_lock, p0_lock};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};

  // Lock owner keeps the port while it asks for it, unless it has used up its
  // burst and the other port is waiting; that exit masks the owner for one pick.
  assign in_lock     = (state_q != StFree);
  assign owner       = (state_q == StLock1);
  assign owner_wants = in_lock & req[owner] & lock[owner];
  assign owner_cont  = owner_wants & ((burst_q < MaxCnt) | ~req[~owner]);
  assign burst_exit  = owner_wants & ~owner_cont;
  assign arb_mask    = burst_exit ? port_onehot(owner) : 2'b00;

  dmem_arbiter_rr_arb2 u_rr_arb2 (
    .req      (req),
    .mask     (arb_mask),
    .last_gnt (last_gnt_q),
    .gnt      (rr_gnt)
  );

  assign gnt    = owner_cont ? port_onehot(owner) : rr_gnt;
  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  // Memory-side muxing of the granted access; everything is 0 when idle.
  assign any_gnt      = |gnt;
  assign sel          = gnt[1];
  assign sel_addr     = addr[sel];
  assign sel_in_range = (32'(sel_addr) < DEPTH);

  assign mem_address   = any_gnt ? 32'(sel_addr) : 32'd0;
  assign mem_writeData = any_gnt ? wdata[sel] : 32'd0;
  assign mem_MemWrite  = any_gnt & we[sel] & sel_in_range;
  assign mem_MemRead   = any_gnt & ~we[sel];
  assign mem_MemtoReg  = mem_MemRead;
  assign mem_ALUResult = 32'd0;

  // Next arbitration state: extend the current lock or fall back to a free pick.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    last_gnt_d = last_gnt_q;
    if (owner_cont) begin
      if (burst_q < MaxCnt) begin
        burst_d = burst_q + cnt_t'(1);
      end
      last_gnt_d = owner;
    end else begin
      state_d = StFree;
      burst_d = '0;
      if (any_gnt) begin
        last_gnt_d = sel;
        if (lock[sel]) begin
          state_d = sel ? StLock1 : StLock0;
          burst_d = cnt_t'(1);
        end
      end
    end
  end

  // Arbitration state registers; reset releases any lock and favours port 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StFree;
      burst_q    <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Response registers: capture the read word at the grant edge; reset drops it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rvalid_q[i] <= gnt[i] & ~we[i];
        err_q[i]    <= gnt[i] & ~sel_in_range;
        if (gnt[i] & ~we[i]) begin
          rdata_q[i] <= sel_in_range ? mem_readData : OorData;
        end
      end
    end
  end

  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata  = rdata_q[0];
  assign p1_rdata  = rdata_q[1];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DEPTH     = 128;
  localparam int unsigned MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [31:0]       p0_wdata, p1_wdata;
  logic              p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0]       p0_rdata, p1_rdata;
  logic [31:0]       mem_address, mem_writeData, mem_ALUResult, mem_readData;
  logic              mem_MemWrite, mem_MemRead, mem_MemtoReg;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .p0_req        (p0_req),
    .p0_we         (p0_we),
    .p0_lock       (p0_lock),
    .p0_addr       (p0_addr),
    .p0_wdata      (p0_wdata),
    .p0_gnt        (p0_gnt),
    .p0_rvalid     (p0_rvalid),
    .p0_rdata      (p0_rdata),
    .p0_err        (p0_err),
    .p1_req        (p1_req),
    .p1_we         (p1_we),
    .p1_lock       (p1_lock),
    .p1_addr       (p1_addr),
    .p1_wdata      (p1_wdata),
    .p1_gnt        (p1_gnt),
    .p1_rvalid     (p1_rvalid),
    .p1_rdata      (p1_rdata),
    .p1_err        (p1_err),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_MemWrite  (mem_MemWrite),
    .mem_MemRead   (mem_MemRead),
    .mem_MemtoReg  (mem_MemtoReg),
    .mem_ALUResult (mem_ALUResult),
    .mem_readData  (mem_readData)
  );

  function automatic logic [31:0] init_word(input int a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_0203);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment memory: combinational read, write at the clock edge.
  logic [31:0] env_mem [256];
  assign mem_readData = env_mem[mem_address[7:0]];
  always @(posedge clk) begin
    if (mem_MemWrite) env_mem[mem_address[7:0]] <= mem_writeData;
  end

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem [128];
  int          m_owner = -1;  // port holding a lock, -1 when none
  int          m_run   = 0;   // grants taken in the current locked run
  int          m_last  = 1;
  bit          e_rvalid [2] = '{0, 0};
  bit          e_err    [2] = '{0, 0};
  logic [31:0] e_rdata  [2] = '{32'd0, 32'd0};

  bit          r [2], w [2], l [2];
  int          a [2];
  logic [31:0] d [2];
  int          win, excl;
  bit          cont, c0, c1, emw, emr;
  logic [1:0]  eg;
  logic [31:0] ea, ewd;

  always @(negedge clk) begin
    if (started) begin
      r[0] = p0_req; r[1] = p1_req;
      w[0] = p0_we;  w[1] = p1_we;
      l[0] = p0_lock; l[1] = p1_lock;
      a[0] = int'(p0_addr); a[1] = int'(p1_addr);
      d[0] = p0_wdata; d[1] = p1_wdata;
      win = -1; excl = -1; cont = 1'b0;
      if (m_owner >= 0 && r[m_owner] && l[m_owner]) begin
        if (m_run < MAX_BURST || !r[1-m_owner]) begin
          win = m_owner; cont = 1'b1;
        end else begin
          excl = m_owner;
        end
      end
      if (win < 0) begin
        c0 = r[0] && excl != 0;
        c1 = r[1] && excl != 1;
        if (c0 && c1) win = (m_last == 0) ? 1 : 0;
        else if (c0) win = 0;
        else if (c1) win = 1;
      end
      eg = 2'b00; ea = '0; ewd = '0; emw = 1'b0; emr = 1'b0;
      if (win >= 0) begin
        eg[win] = 1'b1;
        ea  = 32'(a[win]);
        ewd = d[win];
        emw = w[win] && a[win] < DEPTH;
        emr = !w[win];
      end
      chk("gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, eg});
      chk("mem_address", mem_address, ea);
      chk("mem_writeData", mem_writeData, ewd);
      chk("mem_MemWrite", {31'd0, mem_MemWrite}, {31'd0, emw});
      chk("mem_MemRead", {31'd0, mem_MemRead}, {31'd0, emr});
      chk("mem_MemtoReg", {31'd0, mem_MemtoReg}, {31'd0, emr});
      chk("mem_ALUResult", mem_ALUResult, 32'd0);
      chk("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, e_rvalid[0]});
      chk("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, e_rvalid[1]});
      chk("p0_err", {31'd0, p0_err}, {31'd0, e_err[0]});
      chk("p1_err", {31'd0, p1_err}, {31'd0, e_err[1]});
      chk("p0_rdata", p0_rdata, e_rdata[0]);
      chk("p1_rdata", p1_rdata, e_rdata[1]);
      // Advance to the state after the coming edge.
      if (!rst_n) begin
        m_owner = -1; m_run = 0; m_last = 1;
        e_rvalid = '{0, 0}; e_err = '{0, 0}; e_rdata = '{32'd0, 32'd0};
      end else begin
        e_rvalid = '{0, 0}; e_err = '{0, 0};
        if (win >= 0) begin
          if (!w[win]) begin
            e_rvalid[win] = 1'b1;
            e_rdata[win]  = (a[win] < DEPTH) ? ref_mem[a[win]] : 32'hDEAD_BEEF;
          end
          e_err[win] = (a[win] >= DEPTH);
          m_last = win;
          if (cont) begin
            if (m_run < MAX_BURST) m_run = m_run + 1;
          end else if (l[win]) begin
            m_owner = win; m_run = 1;
          end else begin
            m_owner = -1; m_run = 0;
          end
        end else begin
          m_owner = -1; m_run = 0;
        end
      end
      // Granted writes reach memory even while reset is held.
      if (win >= 0 && emw) ref_mem[a[win]] = d[win];
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int p, input bit rq, input bit wv, input bit lk,
                       input logic [7:0] ad, input logic [31:0] wd);
    if (p == 0) begin
      p0_req = rq; p0_we = wv; p0_lock = lk; p0_addr = ad; p0_wdata = wd;
    end else begin
      p1_req = rq; p1_we = wv; p1_lock = lk; p1_addr = ad; p1_wdata = wd;
    end
  endtask

  task automatic idle(input int p);
    drive(p, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int p);
    bit rq, wv, lk;
    logic [7:0] ad;
    rq = ($urandom_range(0, 3) != 0);
    wv = ($urandom_range(0, 2) == 0);
    lk = 1'($urandom_range(0, 1));
    ad = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15));
    drive(p, rq, wv, lk, ad, $urandom);
  endtask

  logic [1:0] t4_exp [7];
  logic [1:0] gv;
  int         p0_left, p1_left, wait0, wait1, max_wait;

  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = init_word(i);
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    idle(0); idle(1);
    step();
    started = 1'b1;

    // Reset held with both ports requesting.
    drive(0, 1, 0, 0, 8'd1, 32'd0);
    drive(1, 1, 0, 0, 8'd2, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
      chk("rst_err", {30'd0, p1_err, p0_err}, 32'd0);
      chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
      step();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt_p0", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    step(); idle(0);
    @(negedge clk);
    chk("second_gnt_p1", {30'd0, p1_gnt, p0_gnt}, 32'd2);
    chk("p0_rdata_a1", p0_rdata, init_word(1));
    step(); idle(1);
    @(negedge clk);
    chk("p1_rdata_a2", p1_rdata, init_word(2));
    step();

    // Write by p0 then read of the same word by p1.
    drive(0, 1, 1, 0, 8'd5, 32'h1234_5678);
    @(negedge clk);
    chk("wr5_gnt", {31'd0, p0_gnt}, 32'd1);
    step(); idle(0);
    drive(1, 1, 0, 0, 8'd5, 32'd0);
    step(); idle(1);
    @(negedge clk);
    chk("raw_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd2);
    chk("raw_rdata", p1_rdata, 32'h1234_5678);
    step();

    // Continuous reads from both ports alternate.
    drive(0, 1, 0, 0, 8'd10, 32'd0);
    drive(1, 1, 0, 0, 8'd11, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("alt_gnt", {30'd0, p1_gnt, p0_gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) chk("alt_rvalid", {30'd0, p1_rvalid, p0_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd2);
      step();
      drive(k % 2, 1, 0, 0, 8'(12 + k), 32'd0);
    end
    idle(0); idle(1);
    step();

    // Locked burst from p0 is cut after MAX_BURST grants for a waiting p1.
    t4_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    p0_left = 6; p1_left = 1;
    drive(0, 1, 0, 1, 8'd40, 32'd0);
    drive(1, 1, 0, 0, 8'd41, 32'd0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      gv = {p1_gnt, p0_gnt};
      chk("burst_gnt", {30'd0, gv}, {30'd0, t4_exp[k]});
      step();
      if (gv[0]) begin
        p0_left--;
        if (p0_left == 0) idle(0);
        else drive(0, 1, 0, 1, 8'(40 + k), 32'd0);
      end
      if (gv[1]) begin
        p1_left--;
        if (p1_left == 0) idle(1);
      end
    end
    idle(0); idle(1);
    step();

    // Top valid word, then out-of-range write and read.
    drive(1, 1, 0, 0, 8'd127, 32'd0);
    step();
    drive(1, 1, 1, 0, 8'd127, 32'hCAFE_F00D);
    @(negedge clk);
    chk("a127_rdata", p1_rdata, init_word(127));
    chk("a127_err", {31'd0, p1_err}, 32'd0);
    step();
    drive(1, 1, 1, 0, 8'd200, 32'h0BAD_0BAD);
    step();
    drive(1, 1, 0, 0, 8'd200, 32'd0);
    @(negedge clk);
    chk("oor_wr_err", {30'd0, p1_err, p1_rvalid}, 32'd2);
    step();
    drive(1, 1, 0, 0, 8'd127, 32'd0);
    @(negedge clk);
    chk("oor_rd_resp", {30'd0, p1_err, p1_rvalid}, 32'd3);
    chk("oor_rdata", p1_rdata, 32'hDEAD_BEEF);
    step(); idle(1);
    @(negedge clk);
    chk("a127_new", p1_rdata, 32'hCAFE_F00D);
    chk("oor_mem_intact", env_mem[200], init_word(200));
    step();

    // Reset at the edge of a granted locked read discards its response.
    drive(0, 1, 0, 1, 8'd20, 32'd0);
    step();
    drive(0, 1, 0, 1, 8'd21, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("pre_rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    step();
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 8'd30, 32'd0);
    drive(1, 1, 0, 0, 8'd31, 32'd0);
    @(negedge clk);
    chk("post_rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    chk("post_rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    step(); idle(0);
    step(); idle(1);
    step();

    // Randomized traffic with occasional resets.
    wait0 = 0; wait1 = 0; max_wait = 0;
    new_req(0); new_req(1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gv = {p1_gnt, p0_gnt};
      wait0 = (p0_req && !gv[0]) ? wait0 + 1 : 0;
      wait1 = (p1_req && !gv[1]) ? wait1 + 1 : 0;
      if (wait0 > max_wait) max_wait = wait0;
      if (wait1 > max_wait) max_wait = wait1;
      step();
      rst_n = ($urandom_range(0, 63) != 0);
      if (!p0_req || gv[0]) new_req(0);
      if (!p1_req || gv[1]) new_req(1);
    end
    rst_n = 1'b1;
    idle(0); idle(1);
    step(); step();
    chk("fair_wait_ok", {31'd0, max_wait <= MAX_BURST}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
